semafor_intersectie_param: RTL and testbench
============================================

// Module: semafor_intersectie_param
// PURPOSE
//  Parametrised four-way traffic-light controller, next generation of generatorSemafor.
//  Drives N/S and E/V car heads as two axes plus a pedestrian-on-request phase.
//  All phase durations are parameters, counted in prescaled ticks. Adds a flashing-yellow service mode.
//  Top-level block of the intersection design; instantiated directly by the system bench.
// PARAMETERS
//  TICK_DIV    4  clk_i cycles per timing tick (>=1)
//  T_GREEN     5  ticks of green per car axis (>=1)
//  T_YELLOW    2  ticks of yellow per car axis (>=1)
//  T_ALLRED    1  ticks of all-red clearance (>=1)
//  T_PED       3  ticks of pedestrian green (>=1)
//  BLINK_HALF  2  ticks of yellow on (then off) in service mode (>=1)
// PORTS
//  clk_i            in   1  single clock, rising edge
//  reset_i          in   1  synchronous, active-high reset
//  enable_i         in   1  1 = run; 0 = freeze state, timer and prescaler
//  service_i        in   1  1 = flashing-yellow service mode; level-sensitive
//  ped_req_i        in   1  pedestrian button, level, sampled every cycle
//  rosu_auto_o      out  4  car red; bit index N=0 S=1 E=2 V=3
//  galben_auto_o    out  4  car yellow, same indexing
//  verde_auto_o     out  4  car green, same indexing
//  rosu_pietoni_o   out  1  pedestrian red
//  verde_pietoni_o  out  1  pedestrian green
//  faza_o           out  3  current state encoding (package enum)
//  ped_pending_o    out  1  latched pedestrian request
// BEHAVIOUR
//  - States:
//    AR_B = reset/entry state
//    sequence: AR_B -> NS_G -> NS_Y -> AR_A -> EV_G -> EV_Y -> AR_B
//    AR_B exit: -> PED_G if ped_pending, else -> NS_G; PED_G -> PED_CLR -> NS_G
//    SERV is entered only via service_i
//  - Dwell: NS_G/EV_G T_GREEN, NS_Y/EV_Y T_YELLOW, AR_A/AR_B/PED_CLR T_ALLRED, PED_G T_PED
//  - Timer: on state entry, timer <= T-1 and prescaler <= 0. A tick fires when prescaler==TICK_DIV-1.
//    On a tick, timer decrements. A tick with timer==0 advances the state.
//    Every state therefore lasts exactly T*TICK_DIV enabled cycles.
//  - Outputs are decoded from the state register; no extra latency. Exactly one of R/Y/G per head.
//    NS_G: N,S green; E,V red.  NS_Y: N,S yellow; E,V red.  EV_G/EV_Y mirror this.
//    AR_*/PED_CLR: all car red. PED_G: all car red, verde_pietoni_o=1. Otherwise rosu_pietoni_o=1.
//  - SERV: all car R/G = 0; galben_auto_o = 4'hF for BLINK_HALF ticks, then 4'h0 for BLINK_HALF ticks, repeating.
//    Blink starts "on" at entry. Both pedestrian outputs are 0.
//  - Priority each cycle: reset_i > service_i > enable_i.
//    service_i=1 -> SERV on the next edge from any state, even mid-phase.
//    service_i falling -> AR_B with a fresh timer. The pedestrian latch is kept.
//  - enable_i=0: state, timer, prescaler and blink phase all hold; outputs hold.
//    ped_req_i is still latched. service_i still overrides.
//  - ped_pending is set by ped_req_i=1 in any state except PED_G. It is cleared on entry to PED_G.
//    A request held during PED_G does not re-arm.
//  - Reset values: state AR_B, timer T_ALLRED-1, prescaler 0, ped_pending 0.
//    rosu_auto_o=4'hF, galben/verde_auto_o=0, rosu_pietoni_o=1, verde_pietoni_o=0, faza_o=AR_B.
//  - Reset mid-phase: next cycle is the full reset state, regardless of service_i or enable_i.
//  - Timer width = $clog2(max(T_*)+1); prescaler width = $clog2(TICK_DIV+1).
//    No wrap: the timer is reloaded before it underflows.
// STRUCTURE
//  - Package semafor_pkg:
//    faza_t enum {AR_B, NS_G, NS_Y, AR_A, EV_G, EV_Y, PED_G, PED_CLR, SERV} (4 bits, faza_o = low 3 bits + SERV=3'b111 remap)
//    direction indices DIR_N/S/E/V; light-vector constants ALL_RED / NS_ONLY / EV_ONLY.
//  - Sub-module semafor_tick_gen: prescaler with enable and sync clear, emits a 1-cycle tick.
//  - Top: FSM, phase timer, pedestrian latch, blink toggle, output decode.
// TESTING (defaults: TICK_DIV=4, T_GREEN=5, T_YELLOW=2, T_ALLRED=1, T_PED=3, BLINK_HALF=2)
//  1. Reset 3 cycles, enable=1 -> AR_B for 4 cycles, then NS_G for 20 cycles (verde_auto_o=4'b0011).
//     Then NS_Y for 8 cycles, AR_A 4, EV_G 20 (verde_auto_o=4'b1100), EV_Y 8, AR_B 4. Full cycle = 64.
//  2. 1-cycle ped_req_i pulse during EV_G -> ped_pending_o=1.
//     After AR_B: PED_G for 12 cycles (verde_pietoni_o=1, rosu_auto_o=4'hF), PED_CLR 4, NS_G; pending=0.
//  3. ped_req_i held high through PED_G -> no second PED_G in the next cycle; pending stays 0 until PED_G exits.
//  4. service_i=1 mid NS_G -> next cycle galben_auto_o=4'hF, pedestrian outputs 0.
//     Then 8 cycles on / 8 off, repeating. service_i=0 -> AR_B, 4 cycles, then NS_G.
//  5. enable_i=0 for 10 cycles mid NS_Y -> outputs frozen. After re-enable, NS_Y ends 10 cycles later than unpaused.
//  6. reset_i pulse with service_i=1 and enable_i=0 -> reset values next cycle.
//     After release: SERV (service wins), every head has at most one lamp lit at all times (assertion).

Source files
------------

// File: rtl/semafor_pkg.sv
// Shared types and constants for the four-way intersection controller.
// Phase enum, lamp-head indices, light-vector constants, faza_o encoding.
package semafor_pkg;

  typedef enum logic [3:0] {
    AR_B    = 4'd0,
    NS_G    = 4'd1,
    NS_Y    = 4'd2,
    AR_A    = 4'd3,
    EV_G    = 4'd4,
    EV_Y    = 4'd5,
    PED_G   = 4'd6,
    PED_CLR = 4'd7,
    SERV    = 4'd8
  } faza_t;

  localparam int DIR_N = 0;
  localparam int DIR_S = 1;
  localparam int DIR_E = 2;
  localparam int DIR_V = 3;

  localparam logic [3:0] ALL_RED = 4'hF;
  localparam logic [3:0] NS_ONLY =
    (4'b1 << DIR_N) | (4'b1 << DIR_S);
  localparam logic [3:0] EV_ONLY =
    (4'b1 << DIR_E) | (4'b1 << DIR_V);

  // External 3-bit phase code; SERV folds onto 3'b111.
  function automatic logic [2:0] faza_code(faza_t f);
    return (f == SERV) ? 3'b111 : f[2:0];
  endfunction

endpackage

// File: rtl/semafor_intersectie_param_tick_gen.sv
// Prescaler: counts enabled cycles, emits a 1-cycle tick every DIV.
// Ports: clk, reset (sync), en (hold when 0), clr (sync clear), tick.
module semafor_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/semafor_intersectie_param.sv
// Four-way traffic-light controller with pedestrian phase and service blink.
// Ports: clk_i, reset_i, enable_i, service_i, ped_req_i -> car/ped lamps, faza_o, ped_pending_o.
module semafor_intersectie_param
  import semafor_pkg::*;
#(
  parameter int TICK_DIV   = 4,
  parameter int T_GREEN    = 5,
  parameter int T_YELLOW   = 2,
  parameter int T_ALLRED   = 1,
  parameter int T_PED      = 3,
  parameter int BLINK_HALF = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic       service_i,
  input  logic       ped_req_i,
  output logic [3:0] rosu_auto_o,
  output logic [3:0] galben_auto_o,
  output logic [3:0] verde_auto_o,
  output logic       rosu_pietoni_o,
  output logic       verde_pietoni_o,
  output logic [2:0] faza_o,
  output logic       ped_pending_o
);

  // Blink half-period shares the phase timer, so it sets the width too.
  localparam int M1 = (T_GREEN > T_YELLOW) ? T_GREEN : T_YELLOW;
  localparam int M2 = (T_ALLRED > T_PED) ? T_ALLRED : T_PED;
  localparam int M3 = (M1 > M2) ? M1 : M2;
  localparam int TMAX = (M3 > BLINK_HALF) ? M3 : BLINK_HALF;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [TW-1:0] LD_G  = TW'(T_GREEN - 1);
  localparam logic [TW-1:0] LD_Y  = TW'(T_YELLOW - 1);
  localparam logic [TW-1:0] LD_AR = TW'(T_ALLRED - 1);
  localparam logic [TW-1:0] LD_P  = TW'(T_PED - 1);
  localparam logic [TW-1:0] LD_B  = TW'(BLINK_HALF - 1);

  faza_t         state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          blink_q, blink_d;
  logic          pend_q, pend_d;
  logic          clr;
  logic          tick;

  semafor_tick_gen #(
    .DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk_i),
    .reset(reset_i),
    .en   (enable_i),
    .clr  (clr),
    .tick (tick)
  );

  function automatic faza_t succ(faza_t s, logic pend);
    unique case (s)
      AR_B:    return pend ? PED_G : NS_G;
      NS_G:    return NS_Y;
      NS_Y:    return AR_A;
      AR_A:    return EV_G;
      EV_G:    return EV_Y;
      EV_Y:    return AR_B;
      PED_G:   return PED_CLR;
      PED_CLR: return NS_G;
      default: return AR_B;
    endcase
  endfunction

  function automatic logic [TW-1:0] dwell(faza_t s);
    unique case (s)
      NS_G, EV_G: return LD_G;
      NS_Y, EV_Y: return LD_Y;
      PED_G:      return LD_P;
      default:    return LD_AR;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    blink_d = blink_q;
    clr     = 1'b0;
    if (service_i) begin
      if (state_q != SERV) begin
        state_d = SERV;
        tmr_d   = LD_B;
        blink_d = 1'b1;
        clr     = 1'b1;
      end else if (tick) begin
        if (tmr_q == '0) begin
          tmr_d   = LD_B;
          blink_d = ~blink_q;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
    end else if (state_q == SERV) begin
      state_d = AR_B;
      tmr_d   = LD_AR;
      clr     = 1'b1;
    end else if (tick) begin
      if (tmr_q == '0) begin
        state_d = succ(state_q, pend_q);
        tmr_d   = dwell(state_d);
        clr     = 1'b1;
      end else begin
        tmr_d = tmr_q - 1'b1;
      end
    end
  end

  // Clearing on PED_G entry wins over a request in the same cycle.
  always_comb begin
    pend_d = pend_q;
    if (state_d == PED_G && state_q != PED_G) begin
      pend_d = 1'b0;
    end else if (ped_req_i && state_q != PED_G) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= AR_B;
      tmr_q   <= LD_AR;
      blink_q <= 1'b1;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      blink_q <= blink_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    rosu_auto_o     = ALL_RED;
    galben_auto_o   = 4'h0;
    verde_auto_o    = 4'h0;
    rosu_pietoni_o  = 1'b1;
    verde_pietoni_o = 1'b0;
    unique case (state_q)
      NS_G: begin
        rosu_auto_o  = EV_ONLY;
        verde_auto_o = NS_ONLY;
      end
      NS_Y: begin
        rosu_auto_o   = EV_ONLY;
        galben_auto_o = NS_ONLY;
      end
      EV_G: begin
        rosu_auto_o  = NS_ONLY;
        verde_auto_o = EV_ONLY;
      end
      EV_Y: begin
        rosu_auto_o   = NS_ONLY;
        galben_auto_o = EV_ONLY;
      end
      PED_G: begin
        rosu_pietoni_o  = 1'b0;
        verde_pietoni_o = 1'b1;
      end
      SERV: begin
        rosu_auto_o    = 4'h0;
        galben_auto_o  = blink_q ? 4'hF : 4'h0;
        rosu_pietoni_o = 1'b0;
      end
      default: ;
    endcase
  end

  assign faza_o        = faza_code(state_q);
  assign ped_pending_o = pend_q;

endmodule

// File: tb/tb_semafor_intersectie_param.sv
// Randomized bench for semafor_intersectie_param.
// Reference model counts enabled cycles per phase; compares all outputs each cycle.
module tb_semafor_intersectie_param;

  localparam int DIV = 4;
  localparam int TG = 5;
  localparam int TY = 2;
  localparam int TA = 1;
  localparam int TP = 3;
  localparam int BH = 2;

  localparam int P_ARB  = 0;
  localparam int P_NSG  = 1;
  localparam int P_NSY  = 2;
  localparam int P_ARA  = 3;
  localparam int P_EVG  = 4;
  localparam int P_EVY  = 5;
  localparam int P_PEDG = 6;
  localparam int P_PCLR = 7;
  localparam int P_SERV = 8;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       enable_i = 1'b0;
  logic       service_i = 1'b0;
  logic       ped_req_i = 1'b0;
  logic [3:0] rosu_auto_o;
  logic [3:0] galben_auto_o;
  logic [3:0] verde_auto_o;
  logic       rosu_pietoni_o;
  logic       verde_pietoni_o;
  logic [2:0] faza_o;
  logic       ped_pending_o;

  int n_vec = 0;
  int n_bad = 0;

  int m_ph = P_ARB;
  int m_left = TA * DIV;
  int m_sv = 0;
  bit m_pend = 1'b0;

  semafor_intersectie_param dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .enable_i       (enable_i),
    .service_i      (service_i),
    .ped_req_i      (ped_req_i),
    .rosu_auto_o    (rosu_auto_o),
    .galben_auto_o  (galben_auto_o),
    .verde_auto_o   (verde_auto_o),
    .rosu_pietoni_o (rosu_pietoni_o),
    .verde_pietoni_o(verde_pietoni_o),
    .faza_o         (faza_o),
    .ped_pending_o  (ped_pending_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      assert (32'(rosu_auto_o[i]) + 32'(galben_auto_o[i])
              + 32'(verde_auto_o[i]) <= 1)
        else $error("FAIL lamp_excl head %0d", i);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dur(int ph);
    case (ph)
      P_NSG, P_EVG: return TG * DIV;
      P_NSY, P_EVY: return TY * DIV;
      P_PEDG:       return TP * DIV;
      default:      return TA * DIV;
    endcase
  endfunction

  function automatic int nxt(int ph, bit pend);
    case (ph)
      P_ARB:   return pend ? P_PEDG : P_NSG;
      P_NSG:   return P_NSY;
      P_NSY:   return P_ARA;
      P_ARA:   return P_EVG;
      P_EVG:   return P_EVY;
      P_EVY:   return P_ARB;
      P_PEDG:  return P_PCLR;
      default: return P_NSG;
    endcase
  endfunction

  // {rosu, galben, verde, rosu_ped, verde_ped, faza, pending}
  function automatic logic [17:0] expect_vec();
    logic [3:0] r, y, g;
    logic rp, vp;
    logic [2:0] fz;
    r = 4'hF; y = 4'h0; g = 4'h0; rp = 1'b1; vp = 1'b0;
    fz = (m_ph == P_SERV) ? 3'd7 : 3'(m_ph);
    case (m_ph)
      P_NSG: begin r = 4'b1100; g = 4'b0011; end
      P_NSY: begin r = 4'b1100; y = 4'b0011; end
      P_EVG: begin r = 4'b0011; g = 4'b1100; end
      P_EVY: begin r = 4'b0011; y = 4'b1100; end
      P_PEDG: begin rp = 1'b0; vp = 1'b1; end
      P_SERV: begin
        r = 4'h0; rp = 1'b0;
        y = (((m_sv / (BH * DIV)) % 2) == 0) ? 4'hF : 4'h0;
      end
      default: ;
    endcase
    return {r, y, g, rp, vp, fz, m_pend};
  endfunction

  task automatic model_edge();
    int old_ph;
    bit into_ped;
    old_ph = m_ph;
    into_ped = 1'b0;
    if (reset_i) begin
      m_ph = P_ARB; m_left = dur(P_ARB); m_pend = 1'b0;
      return;
    end
    if (service_i) begin
      if (m_ph != P_SERV) begin
        m_ph = P_SERV; m_sv = 0;
      end else if (enable_i) begin
        m_sv++;
      end
    end else if (m_ph == P_SERV) begin
      m_ph = P_ARB; m_left = dur(P_ARB);
    end else if (enable_i) begin
      m_left--;
      if (m_left == 0) begin
        m_ph = nxt(m_ph, m_pend);
        m_left = dur(m_ph);
        into_ped = (m_ph == P_PEDG);
      end
    end
    if (into_ped) m_pend = 1'b0;
    else if (ped_req_i && old_ph != P_PEDG) m_pend = 1'b1;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("outs", 32'({rosu_auto_o, galben_auto_o, verde_auto_o,
                       rosu_pietoni_o, verde_pietoni_o, faza_o,
                       ped_pending_o}), 32'(expect_vec()));
    end
  endtask

  initial begin
    step(3);
    chk("rst_rosu", 32'(rosu_auto_o), 32'hF);
    chk("rst_faza", 32'(faza_o), 32'd0);
    reset_i = 1'b0;
    enable_i = 1'b1;
    step(14);
    chk("nsg_verde", 32'(verde_auto_o), 32'h3);
    step(30);
    chk("evg_verde", 32'(verde_auto_o), 32'hC);
    ped_req_i = 1'b1;
    step(1);
    ped_req_i = 1'b0;
    chk("ped_pend", 32'(ped_pending_o), 32'd1);
    step(30);
    chk("ped_green", 32'(verde_pietoni_o), 32'd1);
    chk("ped_clr", 32'(ped_pending_o), 32'd0);
    step(25);
    service_i = 1'b1;
    step(1);
    chk("serv_on", 32'(galben_auto_o), 32'hF);
    chk("serv_ped", 32'({rosu_pietoni_o, verde_pietoni_o}), 32'd0);
    step(8);
    chk("serv_off", 32'(galben_auto_o), 32'h0);
    step(20);
    service_i = 1'b0;
    step(30);
    enable_i = 1'b0;
    step(10);
    enable_i = 1'b1;
    step(30);
    ped_req_i = 1'b1;
    step(120);
    ped_req_i = 1'b0;
    step(10);
    service_i = 1'b1;
    enable_i = 1'b0;
    reset_i = 1'b1;
    step(1);
    chk("rst_mid", 32'({rosu_auto_o, faza_o}), 32'({4'hF, 3'd0}));
    reset_i = 1'b0;
    step(1);
    chk("rst_serv", 32'(faza_o), 32'd7);
    service_i = 1'b0;
    enable_i = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      ped_req_i = ($urandom % 25) == 0;
      enable_i = ($urandom % 8) != 0;
      if (($urandom % 150) == 0) service_i = ~service_i;
      reset_i = ($urandom % 1200) == 0;
      step(1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
